hex_keypad_entry: RTL and testbench
===================================

# hex_keypad_entry

- Scans a 4x4 matrix hex keypad and debounces presses, one key at a time.
- Each accepted key is shifted into a 32-bit, 8-digit entry word.
- This is the user-input counterpart of the 8-digit seven-segment display path: `value` is sized and ordered to drive the display controller's `din` directly.
- Digit 0 is `value[3:0]` and holds the most recently entered digit.

## Interface

Parameters:
- `SCAN_DIV`, default 100000: clk cycles per scan tick (1 kHz at 100 MHz); minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive matching samples needed to accept a press or a release; minimum 1, maximum 15.

Ports:
- `clk`, input, 1: 100 MHz system clock. This is the only clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `row`, input, 4: keypad rows, active-low, pulled up, asynchronous to clk.
- `clear`, input, 1: synchronous, active-high. Zeroes `value` and `digit_count`.
- `col`, output, 4: column drive, active-low, one-hot.
- `value`, output, 32: entry word, feeding display `din`.
- `key_code`, output, 4: last accepted key.
- `key_valid`, output, 1: one-cycle pulse per accepted key.
- `digit_count`, output, 4: digits entered, 0..8, saturating.

## Operation

Row sampling:
- `row` passes through a 2-flop synchronizer; the synchronizer output is `rs`.
- A tick occurs when the divider reaches `SCAN_DIV-1`; the divider then wraps to 0.
- `rs` is evaluated only on tick cycles.

Key map:
- Column c is active when `col[c]`=0.
- Row r is pressed when `rs[r]`=0.
- The key code is `{r[1:0], c[1:0]}`, i.e. 4r+c.

States:
- SCAN:
  - On a tick, if `rs` has exactly one 0 bit: latch r and c, set `cnt`=1, go to DEBOUNCE. If `DEBOUNCE_SCANS`=1, go directly to HELD with the accept actions.
  - On a tick otherwise (no bit low, or more than one bit low): rotate to the next column, 0→1→2→3→0.
- DEBOUNCE (column held):
  - On a tick, if `rs` equals the latched pattern, increment `cnt`.
  - When `cnt` reaches `DEBOUNCE_SCANS`, accept the key and go to HELD.
  - On a tick with a mismatch, go to SCAN and advance the column.
- HELD:
  - On the first tick where `rs[r]`=1, set `cnt`=1 and go to RELEASE.
- RELEASE:
  - On a tick with `rs[r]`=1, increment `cnt`. When it reaches `DEBOUNCE_SCANS`, go to SCAN and advance the column.
  - On a tick with `rs[r]`=0, go to HELD. The key is not re-accepted.
  - Changes on other rows are ignored in HELD and RELEASE.

Accept actions (all on one clock edge):
- `key_valid`←1 for that cycle only.
- `key_code`←code.
- `value`←{`value[27:0]`, code}.
- `digit_count`←min(`digit_count`+1, 8).

`clear`:
- Takes priority over an accept in the same cycle: the key is discarded (no `key_valid`, `key_code` unchanged), while the FSM still moves to HELD.
- Does not affect FSM state, `col` or the divider.

Reset:
- `col`=4'b1110, `value`=0, `key_code`=0, `key_valid`=0, `digit_count`=0.
- State is SCAN; divider, `cnt` and synchronizer are all cleared (synchronizer to 4'b1111).
- Asserting reset mid-press aborts the press. A key still held after reset is accepted again once debounced.

## Timing

- `col` changes on the clock edge of a tick, so each column settles for `SCAN_DIV` cycles before it is sampled.
- Press latency: `key_valid` and the `value` update occur at the tick where the `DEBOUNCE_SCANS`-th matching sample is taken.
- The first sample includes 2 cycles of synchronizer delay relative to `row`.
- Key presses are accepted at most one per full press/release cycle. Minimum spacing is 2×`DEBOUNCE_SCANS` ticks.
- All outputs are registered.

## Configuration

`ENTRY_LOCK_EN` (undefined by default):
- Defined: once `digit_count`=8, further accepts still pulse `key_valid` and update `key_code`, but `value` is frozen until `clear`.
- Undefined: `value` keeps shifting, and the oldest digit is lost from `value[31:28]`.

## Test plan

Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3.

1. Reset released, `row`=4'hF: `col` cycles 1110→1101→1011→0111→1110 every 4 clocks. `value`=0 and `key_valid` never asserts.
2. Key r=2, c=1 held cleanly: exactly one `key_valid`. `key_code`=4'h9, `value`=32'h00000009, `digit_count`=1. `col` stays at 1101 until 3 release ticks have elapsed.
3. Bounce: row low for 1 tick, high for 1 tick, then stable low: accepted once. A press lasting only 2 ticks is never accepted.
4. Enter keys 1..8 then 9, without `ENTRY_LOCK_EN`: `value`=32'h23456789, `digit_count`=8. With `ENTRY_LOCK_EN`: `value` stays 32'h12345678 and `key_code`=9.
5. `clear` asserted in the same cycle as an accept: `value`=0, `digit_count`=0, no `key_valid`. The next key entered yields `value`=code.
6. Two rows low in the same column: no accept, and scanning continues. Reset asserted during DEBOUNCE: all outputs return to their reset values immediately.

Source files
------------

// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans a 4x4 active-low hex keypad, debounces one key at a
// time and shifts each accepted key code into an 8-digit (32-bit) entry word.
// The word is laid out to feed the seven-segment display controller's din
// directly. Digit 0 (value[3:0]) is the most recently entered key.
//
// Ports:
//   clk          system clock (only clock)
//   reset        asynchronous active-low reset
//   row[3:0]     keypad rows, active-low, asynchronous to clk
//   clear        synchronous clear of value and digit_count
//   col[3:0]     column drive, active-low one-hot
//   value[31:0]  entry word
//   key_code     last accepted key ({row, col})
//   key_valid    one-cycle pulse per accepted key
//   digit_count  digits entered, saturates at 8
//
// Optional feature macro: ENTRY_LOCK_EN. When defined, value stops shifting
// once 8 digits are held, until clear. key_valid/key_code keep reporting keys.

module hex_keypad_entry #(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    input  logic        clear,
    output logic [3:0]  col,
    output logic [31:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic [3:0]  digit_count
);

    localparam int unsigned DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_N      = 4'(DEBOUNCE_SCANS);
    localparam logic [3:0]  MAX_DIGITS = 4'd8;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        sync1_q, sync2_q;
    logic [3:0]        col_q, col_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [3:0]        pat_q, pat_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       value_q, value_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        digit_count_q, digit_count_d;

    logic              tick;
    logic [3:0]        rs;
    logic [3:0]        rs_low;
    logic              one_low;
    logic [1:0]        rs_row;
    logic [1:0]        col_idx;
    logic              accept;
    logic              advance;
    logic [3:0]        acc_code;
    logic [3:0]        cnt_inc;

    assign tick    = (div_q == DIV_LAST);
    assign rs      = sync2_q;
    assign rs_low  = ~rs;
    // Exactly one row low: nonzero and a power of two.
    assign one_low = (rs_low != 4'd0) && ((rs_low & (rs_low - 4'd1)) == 4'd0);
    assign cnt_inc = cnt_q + 4'd1;

    // Row index of the single low row (only meaningful when one_low).
    always_comb begin
        rs_row = 2'd0;
        unique case (rs_low)
            4'b0010: rs_row = 2'd1;
            4'b0100: rs_row = 2'd2;
            4'b1000: rs_row = 2'd3;
            default: rs_row = 2'd0;
        endcase
    end

    // Index of the column currently driven low.
    always_comb begin
        col_idx = 2'd0;
        unique case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Scan tick divider.
    assign div_d = tick ? '0 : (div_q + DIV_W'(1));

    // Next-state logic for the scan/debounce FSM.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_idx_d = row_idx_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        advance   = 1'b0;
        if (tick) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (one_low) begin
                        row_idx_d = rs_row;
                        pat_d     = rs;
                        cnt_d     = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d = ST_HELD;
                            accept  = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs == pat_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_N) begin
                            state_d = ST_HELD;
                            accept  = 1'b1;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        advance = 1'b1;
                    end
                end
                ST_HELD: begin
                    // Only the latched row matters while the key is down.
                    if (rs[row_idx_q]) begin
                        cnt_d = 4'd1;
                        if (DEB_N == 4'd1) begin
                            state_d = ST_SCAN;
                            advance = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (rs[row_idx_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DEB_N) begin
                            state_d = ST_SCAN;
                            advance = 1'b1;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
        if (advance) begin
            col_d = {col_q[2:0], col_q[3]};
        end
    end

    // Column is held on accept, so the current column index is the key's.
    assign acc_code = {row_idx_d, col_idx};

    // Entry datapath; clear wins over a same-cycle accept.
    always_comb begin
        value_d       = value_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        digit_count_d = digit_count_q;
        if (clear) begin
            value_d       = '0;
            digit_count_d = '0;
        end else if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = acc_code;
`ifdef ENTRY_LOCK_EN
            if (digit_count_q != MAX_DIGITS) begin
                value_d = {value_q[27:0], acc_code};
            end
`else
            value_d = {value_q[27:0], acc_code};
`endif
            if (digit_count_q != MAX_DIGITS) begin
                digit_count_d = digit_count_q + 4'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // Synchronizer, divider, scan and entry registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q       <= 4'hF;
            sync2_q       <= 4'hF;
            div_q         <= '0;
            col_q         <= 4'b1110;
            row_idx_q     <= 2'd0;
            pat_q         <= 4'hF;
            cnt_q         <= 4'd0;
            value_q       <= '0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            digit_count_q <= 4'd0;
        end else begin
            sync1_q       <= row;
            sync2_q       <= sync1_q;
            div_q         <= div_d;
            col_q         <= col_d;
            row_idx_q     <= row_idx_d;
            pat_q         <= pat_d;
            cnt_q         <= cnt_d;
            value_q       <= value_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            digit_count_q <= digit_count_d;
        end
    end

    assign col         = col_q;
    assign value       = value_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign digit_count = digit_count_q;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Bench for hex_keypad_entry: keypad matrix model, scoreboard of expected
// accepts, a vector table for single presses and hand sequences for the
// clear/accept collision, multi-row presses and reset mid-debounce.
module tb_hex_keypad_entry;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [31:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  digit_count;

    logic [15:0] keys;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] val;
        logic [3:0]  cnt;
    } exp_t;

    typedef struct {
        logic [3:0] code;
        int         mode;   // 0 clean, 1 two-tick press, 2 bounce then stable
        logic       acc;
    } vec_t;

    exp_t        sbq[$];
    logic [31:0] exp_val = '0;
    logic [3:0]  exp_cnt = '0;

    hex_keypad_entry #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row         (row),
        .clear       (clear),
        .col         (col),
        .value       (value),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every key_valid pulse must match a queued accept.
    always @(negedge clk) begin
        if (reset === 1'b1 && key_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_key_valid: got key_code %h value %h", key_code, value);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("sb_key_code", 32'(key_code), 32'(e.code));
                check("sb_value", value, e.val);
                check("sb_digit_count", 32'(digit_count), 32'(e.cnt));
            end
        end
    end

    task automatic expect_key(input logic [3:0] code);
        exp_t e;
`ifdef ENTRY_LOCK_EN
        if (exp_cnt != 4'd8) exp_val = {exp_val[27:0], code};
`else
        exp_val = {exp_val[27:0], code};
`endif
        if (exp_cnt < 4'd8) exp_cnt = exp_cnt + 4'd1;
        e.code = code;
        e.val  = exp_val;
        e.cnt  = exp_cnt;
        sbq.push_back(e);
    endtask

    // Returns at the first negedge after column c becomes driven.
    task automatic wait_col(input int c);
        int n = 0;
        while (col[c] == 1'b0 && n < 100) begin @(negedge clk); n++; end
        while (col[c] == 1'b1 && n < 100) begin @(negedge clk); n++; end
        n_checks++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL wait_col: column %0d never driven, col %b", c, col);
        end
    endtask

    task automatic press_clean(input logic [3:0] code, input logic acc);
        if (acc) expect_key(code);
        keys[code] = 1'b1;
        repeat (80) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        check("accept_drained", 32'(sbq.size()), 32'd0);
    endtask

    task automatic apply_vec(input vec_t v);
        case (v.mode)
            1: begin
                wait_col(int'(v.code[1:0]));
                keys[v.code] = 1'b1;
                repeat (8) @(negedge clk);
                keys = '0;
                repeat (40) @(negedge clk);
            end
            2: begin
                if (v.acc) expect_key(v.code);
                wait_col(int'(v.code[1:0]));
                keys[v.code] = 1'b1;
                repeat (4) @(negedge clk);
                keys = '0;
                repeat (4) @(negedge clk);
                keys[v.code] = 1'b1;
                repeat (80) @(negedge clk);
                keys = '0;
                repeat (40) @(negedge clk);
            end
            default: press_clean(v.code, v.acc);
        endcase
        check("vec_value", value, exp_val);
        check("vec_digit_count", 32'(digit_count), 32'(exp_cnt));
        check("vec_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        vec_t        vecs[5];
        logic [3:0]  exp_col;
        logic [3:0]  prev_col;
        int          n;
        int          changes;

        vecs[0] = '{4'h5, 1, 1'b0};
        vecs[1] = '{4'h6, 2, 1'b1};
        vecs[2] = '{4'hF, 0, 1'b1};
        vecs[3] = '{4'h0, 1, 1'b0};
        vecs[4] = '{4'hC, 2, 1'b1};

        reset = 1'b0;
        clear = 1'b0;
        keys  = '0;
        repeat (3) @(negedge clk);
        check("rst_col", 32'(col), 32'h0000000E);
        check("rst_value", value, 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_digit_count", 32'(digit_count), 32'd0);

        // Idle scan: column rotates every SCAN_DIV clocks from release.
        reset = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check("idle_col", 32'(col), 32'(exp_col));
            @(negedge clk);
        end
        check("idle_value", value, 32'd0);

        // Clean press of key 9 (row 2, col 1); column held until release debounced.
        expect_key(4'h9);
        keys[9] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        check("k9_accept_seen", 32'(n < 100), 32'd1);
        check("k9_col_at_accept", 32'(col), 32'h0000000D);
        repeat (20) @(negedge clk);
        check("k9_col_held", 32'(col), 32'h0000000D);
        keys = '0;
        repeat (8) @(negedge clk);
        check("k9_col_release_pending", 32'(col), 32'h0000000D);
        repeat (8) @(negedge clk);
        check("k9_col_moved", 32'(col != 4'b1101), 32'd1);
        repeat (24) @(negedge clk);
        check("k9_value", value, 32'h00000009);
        check("k9_digit_count", 32'(digit_count), 32'd1);
        check("k9_key_code", 32'(key_code), 32'h9);
        check("k9_drained", 32'(sbq.size()), 32'd0);

        for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

        // Fill eight digits, then a ninth.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_val = '0;
        exp_cnt = '0;
        check("clr_value", value, 32'd0);
        check("clr_digit_count", 32'(digit_count), 32'd0);
        for (int k = 1; k <= 9; k++) press_clean(4'(k), 1'b1);
`ifdef ENTRY_LOCK_EN
        check("fill_value", value, 32'h12345678);
`else
        check("fill_value", value, 32'h23456789);
`endif
        check("fill_digit_count", 32'(digit_count), 32'd8);
        check("fill_key_code", 32'(key_code), 32'h9);

        // clear lands on the accept edge of key 6 (third matching tick).
        wait_col(2);
        keys[6] = 1'b1;
        repeat (11) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        exp_val = '0;
        exp_cnt = '0;
        repeat (30) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        check("clracc_value", value, 32'd0);
        check("clracc_digit_count", 32'(digit_count), 32'd0);
        check("clracc_key_code", 32'(key_code), 32'h9);
        press_clean(4'h3, 1'b1);
        check("post_clear_value", value, 32'h00000003);
        check("post_clear_digit_count", 32'(digit_count), 32'd1);

        // Two rows low in one column: never accepted, scanning keeps rotating.
        keys[1] = 1'b1;
        keys[5] = 1'b1;
        prev_col = col;
        changes  = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (col != prev_col) changes++;
            prev_col = col;
        end
        check("multi_row_col_changes", 32'(changes), 32'd16);
        keys = '0;
        repeat (20) @(negedge clk);
        check("multi_row_value", value, 32'h00000003);

        // Reset while debouncing key A, key still held afterwards.
        wait_col(2);
        keys[10] = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_col", 32'(col), 32'h0000000E);
        check("midrst_value", value, 32'd0);
        check("midrst_key_code", 32'(key_code), 32'd0);
        check("midrst_key_valid", 32'(key_valid), 32'd0);
        check("midrst_digit_count", 32'(digit_count), 32'd0);
        exp_val = '0;
        exp_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        expect_key(4'hA);
        repeat (80) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        check("rearm_value", value, 32'h0000000A);
        check("rearm_digit_count", 32'(digit_count), 32'd1);
        check("final_drained", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
